// File: rtl/regfile_wb_bank.sv
// -----------------------------------------------------------------------------
// regfile_wb_bank
//
// Write side and storage of the RV32I integer register file, plus the busy
// scoreboard used by the hazard unit.
//
// - x1..x31 are flip-flop registers written by the writeback port.
//   x0 has no storage and always reads as zero.
// - Every register is driven onto a flat bus for the read-port multiplexers.
// - One busy bit per register: set when a producer issues, cleared when it
//   writes back, and cleared for all registers on a flush.
//
// Parameters
//   XLEN     register width (only 32 is supported)
//   RST_VAL  reset value of x1..x31
//
// Ports
//   clk_i        core clock; all state changes on the rising edge
//   rst_ni       synchronous reset, active low
//   wr_en_i      writeback valid
//   wr_addr_i    writeback destination register
//   wr_data_i    writeback data
//   iss_en_i     an instruction with a destination issues this cycle
//   iss_rd_i     destination of the issuing instruction
//   flush_i      pipeline flush; clears all busy bits
//   rs1_addr_i   hazard query address 1
//   rs2_addr_i   hazard query address 2
//   regs_o       flat register bus; bits [32k+31:32k] hold xk; x0 slice is 0
//   busy_o       scoreboard; bit k set means xk has a pending write
//   rs1_busy_o   query 1 must stall (combinational)
//   rs2_busy_o   query 2 must stall (combinational)
//   wb_unexp_o   one-cycle pulse: the previous writeback hit a non-busy register
// -----------------------------------------------------------------------------
module regfile_wb_bank #(
    parameter int unsigned     XLEN    = 32,
    parameter logic [XLEN-1:0] RST_VAL = '0
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 wr_en_i,
    input  logic [4:0]           wr_addr_i,
    input  logic [XLEN-1:0]      wr_data_i,
    input  logic                 iss_en_i,
    input  logic [4:0]           iss_rd_i,
    input  logic                 flush_i,
    input  logic [4:0]           rs1_addr_i,
    input  logic [4:0]           rs2_addr_i,
    output logic [32*XLEN-1:0]   regs_o,
    output logic [31:0]          busy_o,
    output logic                 rs1_busy_o,
    output logic                 rs2_busy_o,
    output logic                 wb_unexp_o
);

    logic [31:0] wen;
    logic [31:0] iss_hit;
    logic [31:0] busy_reg;
    logic [31:0] busy_next;
    logic        wb_unexp_reg;
    logic        wb_unexp_next;

    // x0: never written, never busy.
    assign wen[0]                = 1'b0;
    assign iss_hit[0]            = 1'b0;
    assign busy_next[0]          = 1'b0;
    assign regs_o[XLEN-1:0]      = '0;

    genvar gi;
    generate
        for (gi = 1; gi < 32; gi++) begin : g_reg
            logic [XLEN-1:0] x_reg;

            assign wen[gi]     = wr_en_i  && (wr_addr_i == 5'(gi));
            assign iss_hit[gi] = iss_en_i && (iss_rd_i  == 5'(gi));

            always_ff @(posedge clk_i) begin
                if (!rst_ni) begin
                    x_reg <= RST_VAL;
                end else if (wen[gi]) begin
                    x_reg <= wr_data_i;
                end
            end

            assign regs_o[gi*XLEN +: XLEN] = x_reg;

            // Flush beats everything; a new producer beats a retiring one,
            // since the retiring write is the older result.
            assign busy_next[gi] = flush_i     ? 1'b0 :
                                   iss_hit[gi] ? 1'b1 :
                                   wen[gi]     ? 1'b0 :
                                                 busy_reg[gi];
        end
    endgenerate

    // Writeback to a register nobody is waiting on; the write itself still
    // happens, this only flags it.
    assign wb_unexp_next = wr_en_i && (wr_addr_i != 5'd0) &&
                           !busy_reg[wr_addr_i] && !flush_i;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            busy_reg     <= '0;
            wb_unexp_reg <= 1'b0;
        end else begin
            busy_reg     <= busy_next;
            wb_unexp_reg <= wb_unexp_next;
        end
    end

    assign busy_o     = busy_reg;
    assign wb_unexp_o = wb_unexp_reg;

    // A writeback landing this cycle releases the stall; the consumer picks
    // the value up through forwarding. busy_reg[0] is always 0, so queries
    // of x0 never stall.
    assign rs1_busy_o = busy_reg[rs1_addr_i] &&
                        !(wr_en_i && (wr_addr_i == rs1_addr_i));
    assign rs2_busy_o = busy_reg[rs2_addr_i] &&
                        !(wr_en_i && (wr_addr_i == rs2_addr_i));

endmodule
